imem_ctrl: RTL and testbench

Instruction-memory controller for the RISC-V core. It owns a DEPTH-word synchronous instruction RAM. The host loads a program into it while the core is held in halt, then the controller releases the core. During run, core fetches and host debug reads share the single RAM port. A fetched HALT_WORD stops the core.

---
 rtl/imem_ctrl_if.sv | 50 +++++
 rtl/imem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_imem_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_ctrl_if.sv
// ============================================================================
//  Module   : imem_ctrl_if
//  Purpose  : Bundle of load, fetch, debug and status signals between the
//             host/core side (master) and the instruction-memory controller
//             (slave).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              load_start;
   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ovf;
   logic              cpu_req;
   logic [7:0]        cpu_pc;
   logic              cpu_gnt;
   logic              cpu_valid;
   logic [DATA_W-1:0] cpu_instr;
   logic              cpu_halt;
   logic              pc_err;
   logic              dbg_req;
   logic [ADDR_W-1:0] dbg_addr;
   logic              dbg_gnt;
   logic              dbg_valid;
   logic [DATA_W-1:0] dbg_rdata;
   logic [15:0]       fetch_cnt;
   logic [1:0]        state;

   modport slave (
      input  load_start, ld_valid, ld_data, ld_last, cpu_req, cpu_pc,
             dbg_req, dbg_addr,
      output ld_ready, ld_ovf, cpu_gnt, cpu_valid, cpu_instr, cpu_halt,
             pc_err, dbg_gnt, dbg_valid, dbg_rdata, fetch_cnt, state
   );

   modport master (
      output load_start, ld_valid, ld_data, ld_last, cpu_req, cpu_pc,
             dbg_req, dbg_addr,
      input  ld_ready, ld_ovf, cpu_gnt, cpu_valid, cpu_instr, cpu_halt,
             pc_err, dbg_gnt, dbg_valid, dbg_rdata, fetch_cnt, state
   );
endinterface

`default_nettype wire

// File: rtl/imem_ctrl.sv
// ============================================================================
//  Module   : imem_ctrl
//  Purpose  : Instruction-memory controller. Owns a DEPTH-word RAM that the
//             host loads while the core is halted, then arbitrates the single
//             RAM port between core fetches (priority) and debug reads until
//             a fetched HALT_WORD stops the core.
//  Options  : DBG_STARVE_EN - when defined, debug reads denied STARVE_LIM
//             consecutive RUN cycles get a forced grant on the next cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_ctrl #(
   parameter int                ADDR_W     = 5,
   parameter int                DATA_W     = 32,
   parameter logic [DATA_W-1:0] HALT_WORD  = 32'h0000_007F,
   parameter int                STARVE_LIM = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   imem_ctrl_if.slave   bus
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int SCNT_W = $clog2(STARVE_LIM + 1);
`ifdef DBG_STARVE_EN
   localparam bit STARVE_EN = 1'b1;
`else
   localparam bit STARVE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_LOAD   = 2'b01,
      S_RUN    = 2'b10,
      S_HALTED = 2'b11
   } state_t;

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_t            state_q;
   logic [ADDR_W:0]   wptr_q;        // extra bit marks "past the end"
   logic              ld_ovf_q;
   logic              pc_err_q;
   logic              cpu_halt_q;
   logic              cpu_valid_q;
   logic [DATA_W-1:0] cpu_instr_q;
   logic              dbg_valid_q;
   logic [DATA_W-1:0] dbg_rdata_q;
   logic [15:0]       fetch_cnt_q;
   logic [SCNT_W-1:0] scnt_q;

   logic              w_in_run;
   logic              w_force;
   logic              w_cpu_gnt;
   logic              w_dbg_gnt;
   logic              w_pc_oob;
   logic              w_we;
   logic              w_starving;
   logic [ADDR_W-1:0] w_raddr;
   logic [DATA_W-1:0] w_rdata;
   logic [DATA_W-1:0] w_fetch;

   // Arbitration: core wins in RUN unless a starved debug read is being forced
   always_comb begin
      w_in_run   = (state_q == S_RUN);
      w_force    = STARVE_EN & w_in_run & bus.dbg_req &
                   (scnt_q == SCNT_W'(STARVE_LIM));
      w_cpu_gnt  = w_in_run & bus.cpu_req & ~w_force;
      w_dbg_gnt  = bus.dbg_req &
                   ((state_q == S_IDLE) | (state_q == S_HALTED) |
                    (w_in_run & (~bus.cpu_req | w_force)));
      w_starving = STARVE_EN & w_in_run & bus.dbg_req & ~w_dbg_gnt;
      w_pc_oob   = (32'(bus.cpu_pc) >= 32'(DEPTH));
      w_raddr    = w_cpu_gnt ? bus.cpu_pc[ADDR_W-1:0] : bus.dbg_addr;
      w_rdata    = mem_q[w_raddr];
      w_fetch    = w_pc_oob ? '0 : w_rdata;
      w_we       = (state_q == S_LOAD) & bus.ld_valid & ~bus.load_start &
                   ~wptr_q[ADDR_W];
   end

   // RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (w_we) begin
         mem_q[wptr_q[ADDR_W-1:0]] <= bus.ld_data;
      end
   end

   // Control FSM with all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wptr_q      <= '0;
         ld_ovf_q    <= 1'b0;
         pc_err_q    <= 1'b0;
         cpu_halt_q  <= 1'b1;
         cpu_valid_q <= 1'b0;
         cpu_instr_q <= '0;
         dbg_valid_q <= 1'b0;
         dbg_rdata_q <= '0;
         fetch_cnt_q <= '0;
         scnt_q      <= '0;
      end else begin
         cpu_valid_q <= w_cpu_gnt;
         dbg_valid_q <= w_dbg_gnt;
         // Halt releases one clock after RUN is entered
         cpu_halt_q  <= (state_q != S_RUN);
         scnt_q      <= w_starving ? scnt_q + 1'b1 : '0;

         if (w_cpu_gnt) begin
            cpu_instr_q <= w_fetch;
            if (w_pc_oob) begin
               pc_err_q <= 1'b1;
            end
            if (fetch_cnt_q != 16'hFFFF) begin
               fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
         end
         if (w_dbg_gnt) begin
            dbg_rdata_q <= w_rdata;
         end

         case (state_q)
            S_IDLE, S_HALTED: begin
               if (bus.load_start) begin
                  state_q     <= S_LOAD;
                  wptr_q      <= '0;
                  ld_ovf_q    <= 1'b0;
                  pc_err_q    <= 1'b0;
                  fetch_cnt_q <= '0;
               end
            end
            S_LOAD: begin
               if (bus.load_start) begin
                  wptr_q   <= '0;
                  ld_ovf_q <= 1'b0;
               end else if (bus.ld_valid) begin
                  if (wptr_q[ADDR_W]) begin
                     ld_ovf_q <= 1'b1;
                  end else begin
                     wptr_q <= wptr_q + 1'b1;
                  end
                  if (bus.ld_last) begin
                     state_q <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               // Halt on the same edge that latches the HALT_WORD fetch
               if (w_cpu_gnt && (w_fetch == HALT_WORD)) begin
                  state_q    <= S_HALTED;
                  cpu_halt_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.ld_ready  = (state_q == S_LOAD);
   assign bus.ld_ovf    = ld_ovf_q;
   assign bus.cpu_gnt   = w_cpu_gnt;
   assign bus.cpu_valid = cpu_valid_q;
   assign bus.cpu_instr = cpu_instr_q;
   assign bus.cpu_halt  = cpu_halt_q;
   assign bus.pc_err    = pc_err_q;
   assign bus.dbg_gnt   = w_dbg_gnt;
   assign bus.dbg_valid = dbg_valid_q;
   assign bus.dbg_rdata = dbg_rdata_q;
   assign bus.fetch_cnt = fetch_cnt_q;
   assign bus.state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_ctrl.sv
// ============================================================================
//  Module   : tb_imem_ctrl
//  Purpose  : Self-checking bench for imem_ctrl with a word-array reference
//             model of the RAM and simple counters for the status outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_ctrl;

   localparam logic [31:0] HALT       = 32'h0000_007F;
   localparam int          DEPTH      = 32;
   localparam int          STARVE_LIM = 8;
`ifdef DBG_STARVE_EN
   localparam bit STARVE_ON = 1'b1;
`else
   localparam bit STARVE_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   imem_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   imem_ctrl #(
      .ADDR_W(5), .DATA_W(32), .HALT_WORD(HALT), .STARVE_LIM(STARVE_LIM)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] mem_m [DEPTH];
   int          fcnt_m;
   bit          pcerr_m, halted_m, ovf_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      do w = $urandom; while (w == HALT);
      return w;
   endfunction

   // Start a load and stream n words; word halt_idx is HALT_WORD
   task automatic do_load(input int n, input int halt_idx, input bit with_dbg);
      int          ptr;
      int          a;
      logic [31:0] w;
      a = $urandom_range(0, 19);
      bus.load_start = 1'b1;
      bus.dbg_req    = with_dbg;
      bus.dbg_addr   = 5'(a);
      #4;
      chk("ld_ready_pre", bus.ld_ready, 0);
      if (with_dbg) chk("dbg_gnt_with_load_start", bus.dbg_gnt, 1);
      step();
      bus.load_start = 1'b0;
      bus.dbg_req    = 1'b0;
      if (with_dbg) begin
         chk("dbg_valid_with_load_start", bus.dbg_valid, 1);
         chk("dbg_rdata_with_load_start", bus.dbg_rdata, mem_m[a]);
      end
      fcnt_m = 0; pcerr_m = 0; halted_m = 0; ovf_m = 0; ptr = 0;
      chk("state_load", bus.state, 2'b01);
      chk("fetch_cnt_cleared", bus.fetch_cnt, 0);
      chk("pc_err_cleared", bus.pc_err, 0);
      chk("ld_ovf_cleared", bus.ld_ovf, 0);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.ld_valid = 1'b0;
            #4;
            step();
         end
         w = (i == halt_idx) ? HALT : rand_word();
         bus.ld_valid = 1'b1;
         bus.ld_data  = w;
         bus.ld_last  = (i == n - 1);
         bus.dbg_req  = (i == 0);
         #4;
         chk("ld_ready", bus.ld_ready, 1);
         if (i == 0) chk("dbg_blocked_in_load", bus.dbg_gnt, 0);
         step();
         bus.dbg_req = 1'b0;
         if (ptr < DEPTH) begin
            mem_m[ptr] = w;
            ptr++;
         end else begin
            ovf_m = 1'b1;
         end
      end
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      chk("state_run", bus.state, 2'b10);
      chk("cpu_halt_first_run", bus.cpu_halt, 1);
      chk("ld_ovf", bus.ld_ovf, 32'(ovf_m));
      #4;
      step();
      chk("cpu_halt_released", bus.cpu_halt, 0);
   endtask

   // One granted fetch followed by one idle cycle
   task automatic fetch(input int pc);
      logic [31:0] exp;
      bus.cpu_req  = 1'b1;
      bus.cpu_pc   = 8'(pc);
      bus.dbg_req  = 1'($urandom_range(0, 1));
      bus.dbg_addr = 5'($urandom);
      #4;
      chk("cpu_gnt", bus.cpu_gnt, 1);
      chk("dbg_gnt_vs_cpu", bus.dbg_gnt, 0);
      step();
      bus.cpu_req = 1'b0;
      bus.dbg_req = 1'b0;
      exp = (pc >= DEPTH) ? 32'h0 : mem_m[pc];
      fcnt_m++;
      if (pc >= DEPTH) pcerr_m = 1'b1;
      if (exp == HALT) halted_m = 1'b1;
      chk("cpu_valid", bus.cpu_valid, 1);
      chk("cpu_instr", bus.cpu_instr, exp);
      chk("fetch_cnt", bus.fetch_cnt, 32'(fcnt_m));
      chk("pc_err", bus.pc_err, 32'(pcerr_m));
      chk("cpu_halt", bus.cpu_halt, 32'(halted_m));
      chk("state_after_fetch", bus.state, halted_m ? 2'b11 : 2'b10);
      #4;
      step();
      chk("cpu_valid_pulse", bus.cpu_valid, 0);
      chk("cpu_instr_hold", bus.cpu_instr, exp);
   endtask

   task automatic dbg_rd(input int a);
      bus.dbg_req  = 1'b1;
      bus.dbg_addr = 5'(a);
      #4;
      chk("dbg_gnt", bus.dbg_gnt, 1);
      step();
      bus.dbg_req = 1'b0;
      chk("dbg_valid", bus.dbg_valid, 1);
      chk("dbg_rdata", bus.dbg_rdata, mem_m[a]);
      #4;
      step();
      chk("dbg_valid_pulse", bus.dbg_valid, 0);
      chk("dbg_rdata_hold", bus.dbg_rdata, mem_m[a]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          pc;
      int          deny;
      bit          exp_dbg;
      logic [31:0] w;
      rst_n = 1'b0;
      bus.load_start = 0; bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
      bus.cpu_req = 0; bus.cpu_pc = '0; bus.dbg_req = 0; bus.dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", bus.state, 2'b00);
      chk("rst_cpu_halt", bus.cpu_halt, 1);
      chk("rst_ld_ovf", bus.ld_ovf, 0);
      chk("rst_pc_err", bus.pc_err, 0);
      chk("rst_fetch_cnt", bus.fetch_cnt, 0);
      chk("rst_cpu_valid", bus.cpu_valid, 0);
      chk("rst_cpu_instr", bus.cpu_instr, 0);
      chk("rst_dbg_valid", bus.dbg_valid, 0);
      chk("rst_dbg_rdata", bus.dbg_rdata, 0);
      chk("rst_ld_ready", bus.ld_ready, 0);
      rst_n = 1'b1;
      step();

      // Program 1: 20 words ending in HALT_WORD, fetched in order
      do_load(20, 19, 1'b0);
      for (int i = 0; i < 20; i++) fetch(i);
      bus.cpu_req = 1'b1;
      #4;
      chk("no_cpu_gnt_halted", bus.cpu_gnt, 0);
      step();
      bus.cpu_req = 1'b0;
      chk("fetch_cnt_frozen", bus.fetch_cnt, 20);
      chk("state_halted", bus.state, 2'b11);
      repeat (3) dbg_rd($urandom_range(0, 19));

      // Program 2: 33 words, overflow, HALT_WORD at word 25
      do_load(33, 25, 1'b1);

      // Contention for three cycles, then debug gets the port
      bus.cpu_req = 1'b1; bus.dbg_req = 1'b1; bus.dbg_addr = 5'd31;
      for (int k = 0; k < 3; k++) begin
         pc = $urandom_range(0, 24);
         bus.cpu_pc = 8'(pc);
         #4;
         chk("arb_cpu_gnt", bus.cpu_gnt, 1);
         chk("arb_dbg_denied", bus.dbg_gnt, 0);
         step();
         fcnt_m++;
         chk("arb_cpu_instr", bus.cpu_instr, mem_m[pc]);
      end
      bus.cpu_req = 1'b0;
      #4;
      chk("arb_dbg_gnt", bus.dbg_gnt, 1);
      step();
      bus.dbg_req = 1'b0;
      chk("arb_dbg_valid", bus.dbg_valid, 1);
      chk("arb_dbg_rdata", bus.dbg_rdata, mem_m[31]);
      chk("arb_fetch_cnt", bus.fetch_cnt, 32'(fcnt_m));
      #4;
      step();

      // Both requests held: debug starves unless the forced grant is built in
      deny = 0;
      bus.cpu_req = 1'b1; bus.dbg_req = 1'b1;
      bus.dbg_addr = 5'($urandom_range(0, 31));
      for (int k = 0; k < 12; k++) begin
         pc = $urandom_range(0, 24);
         bus.cpu_pc = 8'(pc);
         exp_dbg = STARVE_ON && (deny == STARVE_LIM);
         #4;
         chk("starve_cpu_gnt", bus.cpu_gnt, 32'(!exp_dbg));
         chk("starve_dbg_gnt", bus.dbg_gnt, 32'(exp_dbg));
         step();
         if (exp_dbg) begin
            deny = 0;
            chk("starve_dbg_rdata", bus.dbg_rdata, mem_m[bus.dbg_addr]);
         end else begin
            deny++;
            fcnt_m++;
            chk("starve_cpu_instr", bus.cpu_instr, mem_m[pc]);
         end
      end
      bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
      #4;
      step();

      // Out-of-range pc, then the halting fetch, then read the last word
      fetch($urandom_range(0, 24));
      fetch(40);
      fetch($urandom_range(0, 24));
      fetch(25);
      dbg_rd(31);
      chk("ovf_sticky", bus.ld_ovf, 1);

      // Reset in the middle of a load
      bus.load_start = 1'b1;
      #4;
      step();
      bus.load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         w = rand_word();
         bus.ld_valid = 1'b1;
         bus.ld_data  = w;
         #4;
         step();
         mem_m[i] = w;
      end
      bus.ld_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_state", bus.state, 2'b00);
      chk("midrst_cpu_halt", bus.cpu_halt, 1);
      chk("midrst_ld_ovf", bus.ld_ovf, 0);
      chk("midrst_ld_ready", bus.ld_ready, 0);
      step();
      rst_n = 1'b1;
      step();
      dbg_rd($urandom_range(0, 4));
      do_load(20, 19, 1'b0);
      for (int k = 0; k < 5; k++) fetch($urandom_range(0, 18));
      fetch(19);
      dbg_rd($urandom_range(20, 31));
      dbg_rd($urandom_range(20, 31));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
